// File: rtl/aes_rnd_engine.sv
// Iterative AES encryption round engine for AES-128/192/256, one round per clock.
// Round keys are fetched by index from the external key-expansion store.
module aes_rnd_engine #(
    parameter int DATA_W = 128,
    parameter int IDX_W  = 4,
    parameter int DEF_NR = 10
) (
    input  logic              CLK,
    input  logic              rst,
    input  logic              Flush,
    input  logic              In_Valid,
    output logic              In_Ready,
    input  logic [1:0]        Key_Len,
    input  logic [DATA_W-1:0] Plain_txt,
    output logic [IDX_W-1:0]  Key_Idx,
    input  logic [DATA_W-1:0] Rnd_Key,
    output logic              Out_Valid,
    input  logic              Out_Ready,
    output logic [DATA_W-1:0] Cypher_txt,
    output logic              Busy
);

    localparam logic [1:0] S_IDLE  = 2'd0;
    localparam logic [1:0] S_ROUND = 2'd1;
    localparam logic [1:0] S_HOLD  = 2'd2;

    localparam logic [2047:0] SBOX = {
        128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
        128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
        128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
        128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
        128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
        128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
        128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
        128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
    };

    logic [1:0]        r_fsm;
    logic [DATA_W-1:0] r_data;
    logic [DATA_W-1:0] r_cypher;
    logic [IDX_W-1:0]  r_rnd;
    logic [IDX_W-1:0]  r_nr;

    logic              w_accept;
    logic [DATA_W-1:0] w_shift;
    logic [DATA_W-1:0] w_mix;

    // Byte 0 is the most significant byte; the state is column-major (byte = row + 4*col).
    function automatic logic [7:0] getByte(input logic [DATA_W-1:0] s, input int idx);
        return s[DATA_W-1-8*idx -: 8];
    endfunction

    function automatic logic [7:0] xtime(input logic [7:0] b);
        return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
    endfunction

    function automatic logic [DATA_W-1:0] subShift(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] res;
        logic [7:0]        b;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            for (int r = 0; r < 4; r++) begin
                b = getByte(s, r + 4 * ((c + r) % 4));
                res[DATA_W-1-8*(r+4*c) -: 8] = SBOX[2047-8*int'(b) -: 8];
            end
        end
        return res;
    endfunction

    function automatic logic [DATA_W-1:0] mixCols(input logic [DATA_W-1:0] s);
        logic [DATA_W-1:0] res;
        logic [7:0]        a0, a1, a2, a3;
        res = '0;
        for (int c = 0; c < 4; c++) begin
            a0 = getByte(s, 4*c);
            a1 = getByte(s, 4*c+1);
            a2 = getByte(s, 4*c+2);
            a3 = getByte(s, 4*c+3);
            res[DATA_W-1-8*(4*c)   -: 8] = xtime(a0) ^ xtime(a1) ^ a1 ^ a2 ^ a3;
            res[DATA_W-1-8*(4*c+1) -: 8] = a0 ^ xtime(a1) ^ xtime(a2) ^ a2 ^ a3;
            res[DATA_W-1-8*(4*c+2) -: 8] = a0 ^ a1 ^ xtime(a2) ^ xtime(a3) ^ a3;
            res[DATA_W-1-8*(4*c+3) -: 8] = xtime(a0) ^ a0 ^ a1 ^ a2 ^ xtime(a3);
        end
        return res;
    endfunction

    function automatic logic [IDX_W-1:0] decodeNr(input logic [1:0] kl);
        case (kl)
            2'b00:   return IDX_W'(10);
            2'b01:   return IDX_W'(12);
            2'b10:   return IDX_W'(14);
            default: return IDX_W'(DEF_NR);
        endcase
    endfunction

    assign w_shift  = subShift(r_data);
    assign w_mix    = mixCols(w_shift);
    assign w_accept = In_Valid & In_Ready;

    always_comb begin
        case (r_fsm)
            S_IDLE:  In_Ready = 1'b1;
            S_HOLD:  In_Ready = Out_Ready;
            default: In_Ready = 1'b0;
        endcase
    end

    assign Key_Idx    = (r_fsm == S_ROUND) ? r_rnd : '0;
    assign Busy       = (r_fsm == S_ROUND);
    assign Out_Valid  = (r_fsm == S_HOLD);
    assign Cypher_txt = r_cypher;

    // Accepting from HOLD consumes the pending output in the same cycle as the new block.
    always_ff @(posedge CLK or posedge rst) begin
        if (rst) begin
            r_fsm    <= S_IDLE;
            r_data   <= '0;
            r_cypher <= '0;
            r_rnd    <= '0;
            r_nr     <= '0;
        end else if (Flush) begin
            r_fsm <= S_IDLE;
            r_rnd <= '0;
        end else if (w_accept) begin
            r_data <= Plain_txt ^ Rnd_Key;
            r_nr   <= decodeNr(Key_Len);
            r_rnd  <= IDX_W'(1);
            r_fsm  <= S_ROUND;
        end else begin
            case (r_fsm)
                S_ROUND: begin
                    if (r_rnd < r_nr) begin
                        r_data <= w_mix ^ Rnd_Key;
                        r_rnd  <= r_rnd + IDX_W'(1);
                    end else begin
                        r_cypher <= w_shift ^ Rnd_Key;
                        r_fsm    <= S_HOLD;
                    end
                end
                S_HOLD: begin
                    if (Out_Ready) begin
                        r_fsm <= S_IDLE;
                    end
                end
                S_IDLE:  r_fsm <= S_IDLE;
                default: r_fsm <= S_IDLE;
            endcase
        end
    end

endmodule
